// File: rtl/motor_drive_sequencer_pkg.sv
// rtl/motor_drive_sequencer_pkg.sv - shared types, hall sequence helpers and slew step for the drive sequencer
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_SKIP    = 2'b10,
    FC_STALL   = 2'b11
  } fault_code_t;

  // Forward commutation order {Grn,Ylw,Blu}: H0 -> H1 -> ... -> H5 -> H0
  localparam logic [2:0] HALL_H0 = 3'b101;
  localparam logic [2:0] HALL_H1 = 3'b100;
  localparam logic [2:0] HALL_H2 = 3'b110;
  localparam logic [2:0] HALL_H3 = 3'b010;
  localparam logic [2:0] HALL_H4 = 3'b011;
  localparam logic [2:0] HALL_H5 = 3'b001;

  function automatic logic [2:0] hall_next(input logic [2:0] code);
    case (code)
      HALL_H0: hall_next = HALL_H1;
      HALL_H1: hall_next = HALL_H2;
      HALL_H2: hall_next = HALL_H3;
      HALL_H3: hall_next = HALL_H4;
      HALL_H4: hall_next = HALL_H5;
      HALL_H5: hall_next = HALL_H0;
      default: hall_next = code;
    endcase
  endfunction

  function automatic logic [2:0] hall_prev(input logic [2:0] code);
    case (code)
      HALL_H0: hall_prev = HALL_H5;
      HALL_H1: hall_prev = HALL_H0;
      HALL_H2: hall_prev = HALL_H1;
      HALL_H3: hall_prev = HALL_H2;
      HALL_H4: hall_prev = HALL_H3;
      HALL_H5: hall_prev = HALL_H4;
      default: hall_prev = code;
    endcase
  endfunction

  // Compares are done one bit wider so cur+step and target+step never wrap
  function automatic logic [11:0] slew_step(input logic [11:0] target,
                                            input logic [11:0] cur,
                                            input logic [11:0] step);
    logic [12:0] t, c, s;
    t = {1'b0, target};
    c = {1'b0, cur};
    s = {1'b0, step};
    if (t > c + s)
      slew_step = cur + step;
    else if (t + s < c)
      slew_step = cur - step;
    else
      slew_step = target;
  endfunction

endpackage

// File: rtl/motor_drive_sequencer_hall_monitor.sv
// rtl/motor_drive_sequencer_hall_monitor.sv - hall synchronizer, sequence checking, period counter and stall compare
module hall_monitor
  import motor_pkg::*;
#(
  parameter logic [15:0] STALL_PERIODS = 16'd20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_synch_i,
  input  logic        rearm_i,
  input  logic [2:0]  hall_raw_i,
  output logic        legal_edge_o,
  output logic        illegal_evt_o,
  output logic        skip_evt_o,
  output logic        stall_cnt_hit_o,
  output logic [15:0] hall_period_o,
  output logic        period_vld_o
);

  logic [2:0]  sync1_q, sync2_q, prev_q;
  logic        first_q, ill_q, period_vld_q;
  logic [15:0] cnt_q, cnt_d, cnt_inc, hall_period_q;
  logic        is_illegal, load, changed, legal;

  always_comb begin
    is_illegal = (sync2_q == 3'b000) || (sync2_q == 3'b111);
    cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    load       = pwm_synch_i && !is_illegal && first_q;
    changed    = pwm_synch_i && !is_illegal && !first_q && (sync2_q != prev_q);
    legal      = changed && ((sync2_q == hall_next(prev_q)) || (sync2_q == hall_prev(prev_q)));
    cnt_d      = (legal || load) ? 16'd0 : cnt_inc;
  end

  assign legal_edge_o    = legal;
  assign skip_evt_o      = changed && !legal;
  // A lone bad sample is treated as sensor noise; two in a row is a fault
  assign illegal_evt_o   = pwm_synch_i && is_illegal && ill_q;
  assign stall_cnt_hit_o = pwm_synch_i && !load && (cnt_inc >= STALL_PERIODS);
  assign hall_period_o   = hall_period_q;
  assign period_vld_o    = period_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      prev_q        <= 3'b000;
      first_q       <= 1'b1;
      ill_q         <= 1'b0;
      cnt_q         <= 16'd0;
      hall_period_q <= 16'hFFFF;
      period_vld_q  <= 1'b0;
    end else begin
      sync1_q      <= hall_raw_i;
      sync2_q      <= sync1_q;
      period_vld_q <= legal;
      if (legal)
        hall_period_q <= cnt_inc;
      if (pwm_synch_i) begin
        ill_q <= is_illegal;
        cnt_q <= cnt_d;
        if (load || changed)
          prev_q <= sync2_q;
      end
      if (rearm_i)
        first_q <= 1'b1;
      else if (load)
        first_q <= 1'b0;
    end
  end

endmodule

// File: rtl/motor_drive_sequencer.sv
// rtl/motor_drive_sequencer.sv - supervisory FSM owning drive magnitude ramp, regen brake and fault handling
module motor_drive_sequencer
  import motor_pkg::*;
#(
  parameter logic [11:0] RAMP_STEP     = 12'd8,
  parameter logic [15:0] STALL_PERIODS = 16'd20000,
  parameter logic [15:0] FAULT_HOLD    = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] torque_req,
  input  logic        brake_req,
  input  logic        PWM_synch,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  output logic [11:0] drv_mag,
  output logic        brake_n,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] hall_period,
  output logic        period_vld
);

  seq_state_t  state_q, state_d;
  fault_code_t fault_code_q, fault_code_d;
  logic [11:0] drv_mag_q, drv_mag_d;
  logic [15:0] hold_q, hold_d;
  logic        brake_n_q, fault_q, rearm;
  logic        legal_edge, illegal_evt, skip_evt, stall_cnt_hit, fault_evt;

  hall_monitor #(
    .STALL_PERIODS(STALL_PERIODS)
  ) u_hall_monitor (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_synch_i    (PWM_synch),
    .rearm_i        (rearm),
    .hall_raw_i     ({hallGrn, hallYlw, hallBlu}),
    .legal_edge_o   (legal_edge),
    .illegal_evt_o  (illegal_evt),
    .skip_evt_o     (skip_evt),
    .stall_cnt_hit_o(stall_cnt_hit),
    .hall_period_o  (hall_period),
    .period_vld_o   (period_vld)
  );

  always_comb begin
    // A legal edge restarts the count, so it can never be a stall on the same pulse
    fault_evt = illegal_evt | skip_evt |
                (stall_cnt_hit & ~legal_edge & (state_q == ST_RUN) & (drv_mag_q != 12'd0));
    state_d      = state_q;
    fault_code_d = fault_code_q;
    hold_d       = hold_q;
    rearm        = 1'b0;
    if (state_q == ST_FAULT) begin
      if (PWM_synch && (hold_q < FAULT_HOLD))
        hold_d = hold_q + 16'd1;
      if ((hold_q >= FAULT_HOLD) && !en) begin
        state_d      = ST_IDLE;
        fault_code_d = FC_NONE;
        rearm        = 1'b1;
      end
    end else if (fault_evt) begin
      state_d = ST_FAULT;
      hold_d  = 16'd0;
      if (illegal_evt)
        fault_code_d = FC_ILLEGAL;
      else if (skip_evt)
        fault_code_d = FC_SKIP;
      else
        fault_code_d = FC_STALL;
    end else if (brake_req) begin
      state_d = ST_BRAKE;
    end else if (en) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end

    // Brake and fault kill the drive at once; otherwise it only moves on PWM_synch
    drv_mag_d = drv_mag_q;
    if ((state_d == ST_BRAKE) || (state_d == ST_FAULT))
      drv_mag_d = 12'd0;
    else if (PWM_synch)
      drv_mag_d = slew_step((state_d == ST_RUN) ? torque_req : 12'd0, drv_mag_q, RAMP_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fault_code_q <= FC_NONE;
      hold_q       <= 16'd0;
      drv_mag_q    <= 12'd0;
      brake_n_q    <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      hold_q       <= hold_d;
      drv_mag_q    <= drv_mag_d;
      brake_n_q    <= (state_d != ST_BRAKE);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign drv_mag    = drv_mag_q;
  assign brake_n    = brake_n_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// tb/tb_motor_drive_sequencer.sv - directed and randomized checks against a PWM-period reference model
module tb_motor_drive_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] torque_req = 12'd0;
  logic        brake_req = 1'b0;
  logic        PWM_synch = 1'b0;
  logic [2:0]  hall = 3'b101;
  logic        hallGrn, hallYlw, hallBlu;
  logic [11:0] drv_mag;
  logic        brake_n, fault, period_vld;
  logic [1:0]  fault_code;
  logic [15:0] hall_period;

  assign hallGrn = hall[2];
  assign hallYlw = hall[1];
  assign hallBlu = hall[0];

  always #5 clk = ~clk;

  motor_drive_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .torque_req (torque_req),
    .brake_req  (brake_req),
    .PWM_synch  (PWM_synch),
    .hallGrn    (hallGrn),
    .hallYlw    (hallYlw),
    .hallBlu    (hallBlu),
    .drv_mag    (drv_mag),
    .brake_n    (brake_n),
    .fault      (fault),
    .fault_code (fault_code),
    .hall_period(hall_period),
    .period_vld (period_vld)
  );

  int n_checks = 0;
  int n_fail = 0;
  int seq_tab[6] = '{5, 4, 6, 2, 3, 1};
  int hidx = 0;

  // Reference model: mode 0 idle, 1 run, 2 brake, 3 fault; prev_pos -1 = waiting for first sample
  int m_mode, m_drv, m_code, m_hold, m_cnt, m_period, m_prev_pos;
  bit m_vld, m_ill_prev;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hall_pos(input logic [2:0] h);
    for (int i = 0; i < 6; i++)
      if (seq_tab[i] == int'(h)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drv = 0; m_code = 0; m_hold = 0; m_cnt = 0;
    m_period = 65535; m_prev_pos = -1; m_vld = 0; m_ill_prev = 0;
  endtask

  task automatic model_clk(input bit pwm);
    bit ill, skip, stall;
    int p, d, tgt, nxt;
    ill = 0; skip = 0; stall = 0; m_vld = 0;
    if (pwm) begin
      nxt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      p = hall_pos(hall);
      if (p < 0) begin
        ill = m_ill_prev;
        m_ill_prev = 1;
      end else begin
        m_ill_prev = 0;
        if (m_prev_pos < 0) begin
          m_prev_pos = p;
          nxt = 0;
        end else if (p != m_prev_pos) begin
          d = (p - m_prev_pos + 6) % 6;
          if (d == 1 || d == 5) begin
            m_period = nxt; m_vld = 1; nxt = 0;
          end else begin
            skip = 1;
          end
          m_prev_pos = p;
        end
      end
      stall = (nxt >= 20000);
      m_cnt = nxt;
    end
    if (m_mode == 3) begin
      bit leave;
      leave = (m_hold >= 1024) && !en;
      if (pwm && m_hold < 1024) m_hold++;
      if (leave) begin m_mode = 0; m_code = 0; m_prev_pos = -1; end
    end else if (ill || skip || (stall && m_mode == 1 && m_drv != 0)) begin
      m_mode = 3; m_hold = 0;
      m_code = ill ? 1 : (skip ? 2 : 3);
    end else begin
      m_mode = brake_req ? 2 : (en ? 1 : 0);
    end
    if (m_mode >= 2) begin
      m_drv = 0;
    end else if (pwm) begin
      tgt = (m_mode == 1) ? int'(torque_req) : 0;
      d = tgt - m_drv;
      if (d > 8) m_drv += 8;
      else if (d < -8) m_drv -= 8;
      else m_drv = tgt;
    end
  endtask

  task automatic cyc(input bit pwm);
    PWM_synch = pwm;
    @(posedge clk);
    @(negedge clk);
    PWM_synch = 1'b0;
    model_clk(pwm);
    check_eq("drv_mag", drv_mag, m_drv);
    check_eq("brake_n", brake_n, (m_mode == 2) ? 0 : 1);
    check_eq("fault", fault, (m_mode == 3) ? 1 : 0);
    check_eq("fault_code", fault_code, m_code);
    check_eq("period_vld", period_vld, m_vld);
    check_eq("hall_period", hall_period, m_period);
  endtask

  // Idle clocks come first so a hall change made just before has passed the synchronizer
  task automatic pulses(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int j = 1; j < gap; j++) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic set_hall(input int idx);
    hidx = (idx % 6 + 6) % 6;
    hall = 3'(seq_tab[hidx]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; brake_req = 1'b0; torque_req = 12'd0; PWM_synch = 1'b0;
    model_reset();
    #1;
    check_eq("rst_drv_mag", drv_mag, 0);
    check_eq("rst_brake_n", brake_n, 1);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_fault_code", fault_code, 0);
    check_eq("rst_hall_period", hall_period, 16'hFFFF);
    check_eq("rst_period_vld", period_vld, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic recover();
    en = 1'b0; brake_req = 1'b0;
    set_hall(hidx);
    pulses(1, 3);
    pulses(1030, 2);
    cyc(1'b0);
    check_eq("recover_fault", fault, 0);
  endtask

  initial begin
    int injects;
    set_hall(0);
    do_reset();

    // Ramp to 0x100 with forward hall edges every 50 PWM periods
    en = 1'b1; torque_req = 12'h100;
    for (int i = 0; i < 300; i++) begin
      if (i > 0 && i % 50 == 0) set_hall(hidx + 1);
      pulses(1, 3);
      if (i == 0)   check_eq("t1_first_no_vld", period_vld, 0);
      if (i == 15)  check_eq("t1_drv_mid", drv_mag, 128);
      if (i == 31)  check_eq("t1_drv_top", drv_mag, 256);
      if (i == 100) begin
        check_eq("t1_vld", period_vld, 1);
        check_eq("t1_period", hall_period, 50);
      end
    end

    // Brake forces zero on the next clock, release restarts the ramp
    brake_req = 1'b1;
    cyc(1'b0);
    check_eq("t2_brake_drv", drv_mag, 0);
    check_eq("t2_brake_n", brake_n, 0);
    pulses(3, 3);
    brake_req = 1'b0;
    cyc(1'b0);
    pulses(1, 3);
    check_eq("t2_restart", drv_mag, 8);

    // Single illegal sample is tolerated, two in a row fault
    hall = 3'b111;
    pulses(1, 3);
    check_eq("t3_one_ill", fault, 0);
    set_hall(hidx + 1);
    pulses(1, 3);
    check_eq("t3_legal_after", fault, 0);
    hall = 3'b111;
    pulses(2, 3);
    check_eq("t3_fault", fault, 1);
    check_eq("t3_code", fault_code, 1);
    check_eq("t3_drv", drv_mag, 0);
    check_eq("t3_coast", brake_n, 1);
    recover();

    // Skipped step, FAULT held past the hold time while en stays high
    en = 1'b1;
    pulses(2, 3);
    set_hall(hidx + 2);
    pulses(1, 3);
    check_eq("t4_code", fault_code, 2);
    pulses(1100, 2);
    check_eq("t4_held", fault, 1);
    en = 1'b0;
    cyc(1'b0);
    check_eq("t4_exit_fault", fault, 0);
    check_eq("t4_exit_code", fault_code, 0);

    // Stall: zero drive never stalls, nonzero drive with a stale count does
    do_reset();
    en = 1'b1; torque_req = 12'd0;
    pulses(20005, 2);
    check_eq("t5_no_stall_at_zero", fault, 0);
    torque_req = 12'h040;
    pulses(1, 2);
    check_eq("t5_first_step", drv_mag, 8);
    pulses(1, 2);
    check_eq("t5_stall_fault", fault, 1);
    check_eq("t5_stall_code", fault_code, 3);

    // Asynchronous reset mid-ramp
    do_reset();
    en = 1'b1; torque_req = 12'h100;
    pulses(16, 3);
    check_eq("t6_pre_drv", drv_mag, 12'h080);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_drv", drv_mag, 0);
    check_eq("t6_rst_period", hall_period, 16'hFFFF);
    check_eq("t6_rst_fault", fault, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    pulses(1, 3);
    check_eq("t6_first_no_vld", period_vld, 0);
    set_hall(hidx + 1);
    pulses(1, 3);
    check_eq("t6_second_vld", period_vld, 1);

    // Randomized mix of control, torque and hall activity
    injects = 0;
    for (int it = 0; it < 200; it++) begin
      int act;
      act = $urandom_range(0, 11);
      case (act)
        0, 1, 2, 3: pulses($urandom_range(1, 20), 3);
        4, 5: begin set_hall(hidx + 1); pulses(1, 3); end
        6: begin set_hall(hidx - 1); pulses(1, 3); end
        7, 8: torque_req = 12'($urandom_range(0, 4095));
        9: en = ~en;
        10: brake_req = ($urandom_range(0, 3) == 0);
        default: begin
          if (injects < 2) begin
            injects++;
            if ($urandom_range(0, 1) == 1) begin
              hall = 3'b000; pulses(2, 3);
            end else begin
              set_hall(hidx + 3); pulses(1, 3);
            end
          end else begin
            brake_req = 1'b0;
          end
        end
      endcase
      cyc(1'b0);
      if (m_mode == 3) recover();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
